// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared types, HD44780 command bytes and the init-ROM lookup
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POR_WAIT = 3'd0,
        ST_INIT     = 3'd1,
        ST_IDLE     = 3'd2,
        ST_STROBE   = 3'd3,
        ST_WAIT     = 3'd4
    } lcd_state_e;

    typedef enum logic [1:0] {
        SG_IDLE  = 2'd0,
        SG_SETUP = 2'd1,
        SG_PULSE = 2'd2,
        SG_HOLD  = 2'd3
    } strobe_state_e;

    localparam logic [7:0] CMD_CLEAR       = 8'h01;
    localparam logic [7:0] CMD_HOME        = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT    = 8'h03;
    localparam logic [7:0] CMD_ENTRY       = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_OFF = 8'h08;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'h0C;
    localparam logic [7:0] CMD_FUNCSET     = 8'h20;
    localparam logic [7:0] FS_8BIT         = 8'h10;
    localparam logic [7:0] FS_2LINE        = 8'h08;
    localparam logic [7:0] CMD_WAKE        = 8'h30;

    // single: only the high nibble is strobed in 4-bit mode
    typedef struct packed {
        logic [7:0] data;
        logic       single;
        logic       init_wait;
    } rom_entry_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int rom_len(input int bw);
        return (bw == 8) ? 8 : 9;
    endfunction

    function automatic rom_entry_t init_rom(input int bw, input int lines, input logic [3:0] idx);
        rom_entry_t e;
        logic [7:0] fs;
        int         base;
        fs   = CMD_FUNCSET | ((bw == 8) ? FS_8BIT : 8'h00) | ((lines == 2) ? FS_2LINE : 8'h00);
        base = (bw == 8) ? 3 : 4;
        e    = '{data: CMD_WAKE, single: 1'b1, init_wait: 1'b1};
        if (int'(idx) < base) begin
            if (bw == 4 && idx == 4'd3) e.data = CMD_FUNCSET;
        end else begin
            e.single    = 1'b0;
            e.init_wait = 1'b0;
            case (int'(idx) - base)
                0:       e.data = fs;
                1:       e.data = CMD_DISPLAY_OFF;
                2:       e.data = CMD_CLEAR;
                3:       e.data = CMD_ENTRY;
                default: e.data = CMD_DISPLAY_ON;
            endcase
        end
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_strobe_gen.sv
// ============================================================================
// lcd_strobe_gen : one SETUP/PULSE/HOLD E-strobe per start pulse
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lcd_strobe_gen
    import lcd_pkg::*;
#(
    parameter int BUS_WIDTH   = 4,
    parameter int SETUP_CYC   = 1,
    parameter int E_PULSE_CYC = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 rs_i,
    input  logic [BUS_WIDTH-1:0] dat_i,
    output logic                 rs_o,
    output logic                 e_o,
    output logic [BUS_WIDTH-1:0] dout_o,
    output logic                 done_o
);

    localparam int CW = $clog2(max_int(SETUP_CYC, E_PULSE_CYC) + 1);

    strobe_state_e        state_q;
    logic [CW-1:0]        cnt_q;
    logic                 rs_q;
    logic                 e_q;
    logic [BUS_WIDTH-1:0] dout_q;

    // RS/dout are only loaded on start, so they never move while E is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SG_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                SG_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= SG_PULSE;
                        e_q     <= 1'b1;
                        cnt_q   <= CW'(E_PULSE_CYC - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SG_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= SG_HOLD;
                        e_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_q <= SG_SETUP;
                        cnt_q   <= CW'(SETUP_CYC - 1);
                        rs_q    <= rs_i;
                        dout_q  <= dat_i;
                    end else begin
                        state_q <= SG_IDLE;
                    end
                end
            endcase
        end
    end

    assign rs_o   = rs_q;
    assign e_o    = e_q;
    assign dout_o = dout_q;
    assign done_o = (state_q == SG_HOLD);

endmodule

`default_nettype wire

// File: rtl/lcd_hd44780_ctrl.sv
// ============================================================================
// lcd_hd44780_ctrl : HD44780 power-on init plus valid/ready byte writer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int BUS_WIDTH     = 4,
    parameter int LINES         = 2,
    parameter int POR_WAIT_CYC  = 15000,
    parameter int INIT_WAIT_CYC = 4100,
    parameter int SETUP_CYC     = 1,
    parameter int E_PULSE_CYC   = 2,
    parameter int CMD_WAIT_CYC  = 40,
    parameter int CLR_WAIT_CYC  = 1600
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    input  logic                 in_rs_i,
    input  logic [7:0]           in_data_i,
    output logic                 in_ready_o,
    output logic                 init_done_o,
    output logic                 busy_o,
    output logic                 rs_o,
    output logic                 e_o,
    output logic [BUS_WIDTH-1:0] dout_o
);

    localparam int MAX_WAIT = max_int(max_int(POR_WAIT_CYC, INIT_WAIT_CYC),
                                      max_int(CMD_WAIT_CYC, CLR_WAIT_CYC));
    localparam int         CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [3:0] ROM_LAST = 4'(rom_len(BUS_WIDTH));

    if (!(BUS_WIDTH == 4 || BUS_WIDTH == 8)) begin : g_bad_bus_width
        $error("lcd_hd44780_ctrl: BUS_WIDTH must be 4 or 8");
    end
    if (SETUP_CYC < 1 || E_PULSE_CYC < 1) begin : g_bad_strobe_timing
        $error("lcd_hd44780_ctrl: SETUP_CYC and E_PULSE_CYC must be at least 1");
    end

    lcd_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           rom_idx_q;
    logic                 rs_q;
    logic [7:0]           data_q;
    logic                 lo_pending_q;
    logic                 init_wait_q;
    logic                 init_done_q;
    logic                 in_ready_q;

    rom_entry_t           w_rom;
    logic                 w_fire;
    logic                 w_done;
    logic                 w_start;
    logic                 w_rs;
    logic [7:0]           w_byte;
    logic [BUS_WIDTH-1:0] w_bus;
    logic [CNT_W-1:0]     w_wait;

    assign w_rom  = init_rom(BUS_WIDTH, LINES, rom_idx_q);
    assign w_fire = in_ready_q & in_valid_i;

    // Strobe launch sources: ROM entry, accepted byte, or pending low nibble
    always_comb begin
        w_start = 1'b0;
        w_rs    = rs_q;
        w_byte  = data_q;
        case (state_q)
            ST_INIT: begin
                w_start = 1'b1;
                w_rs    = 1'b0;
                w_byte  = w_rom.data;
            end
            ST_IDLE: begin
                w_start = w_fire;
                w_rs    = in_rs_i;
                w_byte  = in_data_i;
            end
            ST_STROBE: w_start = w_done & lo_pending_q;
            default: ;
        endcase
    end

    if (BUS_WIDTH == 8) begin : g_bus8
        assign w_bus = w_byte;
    end else begin : g_bus4
        // A launch from ST_STROBE is always the second (low) nibble
        assign w_bus = (state_q == ST_STROBE) ? w_byte[3:0] : w_byte[7:4];
    end

    always_comb begin
        w_wait = CNT_W'(CMD_WAIT_CYC - 1);
        if (init_wait_q)
            w_wait = CNT_W'(INIT_WAIT_CYC - 1);
        else if (!rs_q && (data_q inside {CMD_CLEAR, CMD_HOME, CMD_HOME_ALT}))
            w_wait = CNT_W'(CLR_WAIT_CYC - 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_POR_WAIT;
            cnt_q        <= CNT_W'(POR_WAIT_CYC - 1);
            rom_idx_q    <= '0;
            rs_q         <= 1'b0;
            data_q       <= '0;
            lo_pending_q <= 1'b0;
            init_wait_q  <= 1'b0;
            init_done_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_POR_WAIT: begin
                    if (cnt_q == '0) state_q <= ST_INIT;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_INIT: begin
                    data_q       <= w_rom.data;
                    rs_q         <= 1'b0;
                    init_wait_q  <= w_rom.init_wait;
                    lo_pending_q <= (BUS_WIDTH == 4) && !w_rom.single;
                    rom_idx_q    <= rom_idx_q + 1'b1;
                    state_q      <= ST_STROBE;
                end
                ST_IDLE: begin
                    if (w_fire) begin
                        in_ready_q   <= 1'b0;
                        data_q       <= in_data_i;
                        rs_q         <= in_rs_i;
                        init_wait_q  <= 1'b0;
                        lo_pending_q <= (BUS_WIDTH == 4);
                        state_q      <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (w_done) begin
                        if (lo_pending_q) begin
                            lo_pending_q <= 1'b0;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= w_wait;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (init_done_q || rom_idx_q == ROM_LAST) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q <= ST_INIT;
                    end
                end
                default: state_q <= ST_POR_WAIT;
            endcase
        end
    end

    lcd_strobe_gen #(
        .BUS_WIDTH   (BUS_WIDTH),
        .SETUP_CYC   (SETUP_CYC),
        .E_PULSE_CYC (E_PULSE_CYC)
    ) u_strobe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (w_start),
        .rs_i    (w_rs),
        .dat_i   (w_bus),
        .rs_o    (rs_o),
        .e_o     (e_o),
        .dout_o  (dout_o),
        .done_o  (w_done)
    );

    assign in_ready_o  = in_ready_q;
    assign init_done_o = init_done_q;
    assign busy_o      = ~in_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_hd44780_ctrl.sv
// ============================================================================
// tb_lcd_hd44780_ctrl : scoreboard bench for 4-bit and 8-bit controller builds
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_lcd_hd44780_ctrl;

    localparam int POR = 20, INITW = 10, SETUP = 1, EP = 2, CMD = 5, CLR = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4_n, v4, rsin4, rdy4, done4, busy4, rs4, e4;
    logic [7:0] d4;
    logic [3:0] dout4;
    logic       rst8_n, v8, rsin8, rdy8, done8, busy8, rs8, e8;
    logic [7:0] d8;
    logic [7:0] dout8;

    lcd_hd44780_ctrl #(.BUS_WIDTH(4), .LINES(2), .POR_WAIT_CYC(POR), .INIT_WAIT_CYC(INITW),
        .SETUP_CYC(SETUP), .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CMD), .CLR_WAIT_CYC(CLR)) dut4 (
        .clk_i(clk), .rst_ni(rst4_n), .in_valid_i(v4), .in_rs_i(rsin4), .in_data_i(d4),
        .in_ready_o(rdy4), .init_done_o(done4), .busy_o(busy4), .rs_o(rs4), .e_o(e4), .dout_o(dout4));

    lcd_hd44780_ctrl #(.BUS_WIDTH(8), .LINES(2), .POR_WAIT_CYC(POR), .INIT_WAIT_CYC(INITW),
        .SETUP_CYC(SETUP), .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CMD), .CLR_WAIT_CYC(CLR)) dut8 (
        .clk_i(clk), .rst_ni(rst8_n), .in_valid_i(v8), .in_rs_i(rsin8), .in_data_i(d8),
        .in_ready_o(rdy8), .init_done_o(done8), .busy_o(busy8), .rs_o(rs8), .e_o(e8), .dout_o(dout8));

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {rs, 8-bit bus value}
    logic [8:0] q4[$];
    logic [8:0] q8[$];
    logic [8:0] init4[14];
    logic [8:0] init8[8];

    int   rises4 = 0, accepts4 = 0, viol4 = 0, len4 = 0, len8 = 0;
    logic pd4 = 1'b0, pe4 = 1'b0, pe8 = 1'b0;
    logic [8:0] snap4, snap8;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst4_n) begin
            pe4 = 1'b0; len4 = 0; pd4 = 1'b0;
        end else begin
            if (done4 && !pd4) rises4++;
            pd4 = done4;
            if (v4 && rdy4) accepts4++;
            if (rdy4 && !done4) viol4++;
            if (e4 && !pe4) begin
                if (q4.size() == 0) check("strobe4_unexpected", 32'(q4.size()), 32'd1);
                else check("strobe4", 32'({rs4, 4'h0, dout4}), 32'(q4.pop_front()));
                snap4 = {rs4, 4'h0, dout4};
                len4  = 1;
            end else if (e4) begin
                len4++;
                check("bus4_stable", 32'({rs4, 4'h0, dout4}), 32'(snap4));
            end else if (pe4) begin
                check("e4_width", 32'(len4), 32'(EP));
            end
            pe4 = e4;
        end
    end

    always @(negedge clk) begin
        if (!rst8_n) begin
            pe8 = 1'b0; len8 = 0;
        end else begin
            if (e8 && !pe8) begin
                if (q8.size() == 0) check("strobe8_unexpected", 32'(q8.size()), 32'd1);
                else check("strobe8", 32'({rs8, dout8}), 32'(q8.pop_front()));
                snap8 = {rs8, dout8};
                len8  = 1;
            end else if (e8) begin
                len8++;
                check("bus8_stable", 32'({rs8, dout8}), 32'(snap8));
            end else if (pe8) begin
                check("e8_width", 32'(len8), 32'(EP));
            end
            pe8 = e8;
        end
    end

    task automatic drive(input bit wide, input logic v, input logic rs, input logic [7:0] d);
        if (wide) begin v8 = v; rsin8 = rs; d8 = d; end
        else      begin v4 = v; rsin4 = rs; d4 = d; end
    endtask

    task automatic wait_init(input bit wide);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = wide ? done8 : done4;
        end
        check(wide ? "init_done8_wait" : "init_done4_wait", 32'(ok), 32'd1);
    endtask

    // Offer one byte, queue its strobes, measure acceptance-to-ready latency
    task automatic send(input bit wide, input logic rs, input logic [7:0] d, input int exp_lat);
        bit ok = 1'b0;
        int n  = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = wide ? rdy8 : rdy4;
        end
        check($sformatf("ready_wait_w%0d_%02h", wide ? 8 : 4, d), 32'(ok), 32'd1);
        if (ok) begin
            if (wide) q8.push_back({rs, d});
            else begin
                q4.push_back({rs, 4'h0, d[7:4]});
                q4.push_back({rs, 4'h0, d[3:0]});
            end
            #1 drive(wide, 1'b1, rs, d);
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                n++;
                ok = wide ? rdy8 : rdy4;
                if (n == 1) #1 drive(wide, 1'b0, rs, d);
            end
            check($sformatf("latency_w%0d_rs%0d_%02h", wide ? 8 : 4, rs, d), 32'(n), 32'(exp_lat));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        init4 = '{9'h003, 9'h003, 9'h003, 9'h002, 9'h002, 9'h008, 9'h000,
                  9'h008, 9'h000, 9'h001, 9'h000, 9'h006, 9'h000, 9'h00C};
        init8 = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
        rst4_n = 1'b1; rst8_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h41);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        #1 rst4_n = 1'b0; rst8_n = 1'b0;
        #1;
        check("rst_e4", 32'(e4), 32'd0);
        check("rst_rs4", 32'(rs4), 32'd0);
        check("rst_dout4", 32'(dout4), 32'd0);
        check("rst_ready4", 32'(rdy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd1);
        check("rst_e8", 32'(e8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd1);
        foreach (init4[i]) q4.push_back(init4[i]);
        foreach (init8[i]) q8.push_back(init8[i]);
        repeat (3) @(negedge clk);
        #1 rst4_n = 1'b1; rst8_n = 1'b1;

        // Init sequence with in_valid held high throughout
        send(1'b0, 1'b1, 8'h41, 14);
        check("init4_strobes_left", 32'(q4.size()), 32'd0);
        check("init4_rises", 32'(rises4), 32'd1);
        check("accepts4_once", 32'(accepts4), 32'd1);
        check("ready4_before_init", 32'(viol4), 32'd0);

        // Clear/home vs ordinary waits
        send(1'b0, 1'b0, 8'h01, 21);
        send(1'b0, 1'b0, 8'h80, 14);
        send(1'b0, 1'b1, 8'h01, 14);
        send(1'b0, 1'b0, 8'h03, 21);
        send(1'b0, 1'b0, 8'h04, 14);
        check("q4_drained", 32'(q4.size()), 32'd0);

        // 8-bit build
        wait_init(1'b1);
        check("init8_strobes_left", 32'(q8.size()), 32'd0);
        send(1'b1, 1'b1, 8'h41, 10);
        send(1'b1, 1'b0, 8'h02, 17);
        check("q8_drained", 32'(q8.size()), 32'd0);

        // Reset while E is high
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = rdy4;
        end
        check("ready4_before_reset", 32'(ok), 32'd1);
        q4.push_back(9'h105);
        q4.push_back(9'h105);
        #1 drive(1'b0, 1'b1, 1'b1, 8'h55);
        @(negedge clk);
        #1 drive(1'b0, 1'b0, 1'b1, 8'h55);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = e4;
        end
        check("e4_high_seen", 32'(ok), 32'd1);
        #1 rst4_n = 1'b0;
        #1;
        check("midrst_e4", 32'(e4), 32'd0);
        check("midrst_ready4", 32'(rdy4), 32'd0);
        check("midrst_done4", 32'(done4), 32'd0);
        check("midrst_busy4", 32'(busy4), 32'd1);
        q4.delete();
        foreach (init4[i]) q4.push_back(init4[i]);
        rises4 = 0;
        repeat (2) @(negedge clk);
        #1 rst4_n = 1'b1;
        send(1'b0, 1'b1, 8'h41, 14);
        check("reinit4_strobes_left", 32'(q4.size()), 32'd0);
        check("reinit4_rises", 32'(rises4), 32'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
